// File: rtl/caravel_lite_pkg.sv
// rtl/caravel_lite_pkg.sv - shared states, opcodes and helpers for the caravel_lite flash player
package caravel_lite_pkg;

  typedef enum logic [2:0] {
    BOOT,
    CMD,
    ADDR,
    DATA,
    EXEC,
    WAIT,
    HALT
  } state_t;

  localparam logic [7:0]  OPCODE_READ = 8'h03;
  localparam logic [31:0] HALT_WORD   = 32'hFFFFFFFF;

  // Address bytes go out most significant first: index 0 is addr[23:16].
  function automatic logic [7:0] addr_byte(input logic [23:0] addr, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = addr[23:16];
      2'd1:    b = addr[15:8];
      default: b = addr[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/caravel_lite_spi_byte_shifter.sv
// rtl/caravel_lite_spi_byte_shifter.sv - 8-bit full-duplex SPI mode 0 shifter with start/done handshake
module spi_byte_shifter (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic [7:0] rx_byte,
  output logic       done
);

  logic       busy;
  logic [7:0] tx_shift;
  logic [2:0] bit_cnt;

  // Load on start, then toggle sclk every cycle; MISO is captured and MOSI advanced on the falling edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy     <= 1'b0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      tx_shift <= 8'h00;
      rx_byte  <= 8'h00;
      bit_cnt  <= 3'd0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (start) begin
          busy     <= 1'b1;
          tx_shift <= tx_byte;
          mosi     <= tx_byte[7];
          bit_cnt  <= 3'd0;
        end
      end else if (!sclk) begin
        sclk <= 1'b1;
      end else begin
        sclk     <= 1'b0;
        rx_byte  <= {rx_byte[6:0], miso};
        tx_shift <= {tx_shift[6:0], 1'b0};
        mosi     <= tx_shift[6];
        bit_cnt  <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/caravel_lite.sv
// rtl/caravel_lite.sv - boots from SPI flash and plays back timed 16-bit check patterns on mprj_io
module caravel_lite
  import caravel_lite_pkg::*;
#(
  parameter int          STARTUP_CYCLES = 16,
  parameter logic [23:0] BASE_ADDR      = 24'h000000,
  parameter int          MAX_WORDS      = 256
) (
  input  logic       clock,
  input  logic       reset,
  output logic       flash_csb,
  output logic       flash_clk,
  output logic       flash_io0,
  input  logic       flash_io1,
  inout  wire [37:0] mprj_io,
  inout  wire        gpio
);

  localparam int              WCW       = $clog2(MAX_WORDS + 1);
  localparam logic [WCW-1:0]  MAX_W     = WCW'(MAX_WORDS);
  localparam logic [15:0]     BOOT_LAST = (STARTUP_CYCLES > 0) ? 16'(STARTUP_CYCLES - 1) : 16'd0;

  state_t         state;
  logic [15:0]    boot_cnt;
  logic [1:0]     byte_idx;
  logic           shift_start;
  logic [7:0]     shift_tx;
  logic [7:0]     shift_rx;
  logic           shift_done;
  logic [31:0]    record;
  logic [15:0]    delay_cnt;
  logic [WCW-1:0] word_cnt;
  logic [15:0]    checkbits;

  spi_byte_shifter u_shifter (
    .clock   (clock),
    .reset   (reset),
    .start   (shift_start),
    .tx_byte (shift_tx),
    .miso    (flash_io1),
    .sclk    (flash_clk),
    .mosi    (flash_io0),
    .rx_byte (shift_rx),
    .done    (shift_done)
  );

  // Boot delay, read command, then fetch/execute records until the halt marker or the word limit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= BOOT;
      boot_cnt    <= 16'd0;
      byte_idx    <= 2'd0;
      shift_start <= 1'b0;
      shift_tx    <= 8'h00;
      record      <= 32'h0;
      delay_cnt   <= 16'd0;
      word_cnt    <= '0;
      checkbits   <= 16'h0000;
      flash_csb   <= 1'b1;
    end else begin
      shift_start <= 1'b0;
      case (state)
        BOOT: begin
          if (boot_cnt >= BOOT_LAST) begin
            flash_csb   <= 1'b0;
            shift_tx    <= OPCODE_READ;
            shift_start <= 1'b1;
            state       <= CMD;
          end else begin
            boot_cnt <= boot_cnt + 16'd1;
          end
        end
        CMD: begin
          if (shift_done) begin
            shift_tx    <= addr_byte(BASE_ADDR, 2'd0);
            shift_start <= 1'b1;
            byte_idx    <= 2'd0;
            state       <= ADDR;
          end
        end
        ADDR: begin
          if (shift_done) begin
            shift_start <= 1'b1;
            if (byte_idx == 2'd2) begin
              shift_tx <= 8'h00;
              byte_idx <= 2'd0;
              state    <= DATA;
            end else begin
              shift_tx <= addr_byte(BASE_ADDR, byte_idx + 2'd1);
              byte_idx <= byte_idx + 2'd1;
            end
          end
        end
        DATA: begin
          if (shift_done) begin
            // First byte received ends up in record[7:0] after four shifts.
            record <= {shift_rx, record[31:8]};
            if (byte_idx == 2'd3) begin
              byte_idx <= 2'd0;
              state    <= EXEC;
            end else begin
              byte_idx    <= byte_idx + 2'd1;
              shift_tx    <= 8'h00;
              shift_start <= 1'b1;
            end
          end
        end
        EXEC: begin
          if (record == HALT_WORD) begin
            flash_csb <= 1'b1;
            state     <= HALT;
          end else begin
            checkbits <= record[31:16];
            delay_cnt <= record[15:0];
            word_cnt  <= word_cnt + 1'b1;
            state     <= WAIT;
          end
        end
        WAIT: begin
          // Chip select stays low so the flash keeps its sequential read position.
          if (delay_cnt == 16'd0) begin
            if (word_cnt == MAX_W) begin
              flash_csb <= 1'b1;
              state     <= HALT;
            end else begin
              shift_tx    <= 8'h00;
              shift_start <= 1'b1;
              byte_idx    <= 2'd0;
              state       <= DATA;
            end
          end else begin
            delay_cnt <= delay_cnt - 16'd1;
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          flash_csb <= 1'b1;
          state     <= HALT;
        end
      endcase
    end
  end

  assign mprj_io[37:32] = 6'bz;
  assign mprj_io[31:16] = checkbits;
  assign mprj_io[15:7]  = 9'bz;
  assign mprj_io[6]     = 1'b1;
  assign mprj_io[5:0]   = 6'bz;
  assign gpio           = 1'bz;

endmodule

// File: tb/tb_caravel_lite.sv
// tb/tb_caravel_lite.sv - scoreboard bench for caravel_lite with a behavioural SPI flash
module tb_caravel_lite;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [23:0] BASE1   = 24'h000010;
  localparam logic [37:0] UNOWNED = 38'h3F0000FFBF;

  logic [1:0] rst  = 2'b11;
  logic [1:0] miso = 2'b00;
  wire  [1:0] csb, fclk, mosi;
  wire  [37:0] mprj0, mprj1;
  wire  gpio0, gpio1;

  caravel_lite dut0 (
    .clock(clk), .reset(rst[0]), .flash_csb(csb[0]), .flash_clk(fclk[0]),
    .flash_io0(mosi[0]), .flash_io1(miso[0]), .mprj_io(mprj0), .gpio(gpio0)
  );

  caravel_lite #(.STARTUP_CYCLES(4), .BASE_ADDR(BASE1), .MAX_WORDS(2)) dut1 (
    .clock(clk), .reset(rst[1]), .flash_csb(csb[1]), .flash_clk(fclk[1]),
    .flash_io0(mosi[1]), .flash_io1(miso[1]), .mprj_io(mprj1), .gpio(gpio1)
  );

  // flash model state
  logic [7:0]  fmem [2][64];
  int          fcnt [2];
  int          rcnt [2];
  int          toggles [2];
  logic [31:0] cap [2];
  logic [1:0]  prev_csb  = 2'b11;
  logic [1:0]  prev_fclk = 2'b00;

  // scoreboard state
  logic [15:0] exp_mem [2][64];
  int          wr [2];
  int          rd [2];
  int          chg_cyc [2][64];
  logic [15:0] prev_cb [2];
  logic        io_bad [2];
  int          cyc;
  int          checks;
  int          failures;

  logic [31:0] prog [16];
  int          nprog;
  int          maxw [2] = '{256, 2};
  logic [23:0] base [2] = '{24'h000000, BASE1};
  logic [15:0] exp_final;

  function automatic logic [37:0] pins(input int k);
    return (k == 0) ? mprj0 : mprj1;
  endfunction

  function automatic logic gp(input int k);
    return (k == 0) ? gpio0 : gpio1;
  endfunction

  function automatic logic flash_bit(input int k, input int f, input logic [23:0] addr);
    int j;
    logic [7:0] b;
    if (f < 32) return 1'b0;
    j = f - 32;
    b = fmem[k][(int'(addr) + j / 8) % 64];
    return b[7 - (j % 8)];
  endfunction

  // SPI flash: captures opcode+address, then streams bytes from the captured address onward.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!csb[k] && prev_csb[k]) begin
        fcnt[k] = 0;
        rcnt[k] = 0;
        cap[k]  = 32'h0;
      end
      if (!csb[k] && fclk[k] && !prev_fclk[k]) begin
        if (rcnt[k] < 32) cap[k] = {cap[k][30:0], mosi[k]};
        rcnt[k]++;
      end
      if (!csb[k] && !fclk[k] && prev_fclk[k]) fcnt[k]++;
      if (fclk[k] != prev_fclk[k]) toggles[k]++;
      prev_csb[k]  = csb[k];
      prev_fclk[k] = fclk[k];
      miso[k]      = flash_bit(k, fcnt[k], cap[k][23:0]);
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic monitor();
    logic [37:0] p;
    forever begin
      @(negedge clk);
      cyc++;
      for (int k = 0; k < 2; k++) begin
        p = pins(k);
        if (p[6] !== 1'b1 || |(p & UNOWNED) === 1'b1 || gp(k) === 1'b1) io_bad[k] = 1'b1;
        if (rst[k]) begin
          prev_cb[k] = 16'h0;
        end else if (p[31:16] !== prev_cb[k]) begin
          checks++;
          if (rd[k] >= wr[k]) begin
            failures++;
            $display("FAIL checkbits_unexpected inst%0d: got %h, expected no change", k, p[31:16]);
          end else begin
            if (p[31:16] !== exp_mem[k][rd[k]]) begin
              failures++;
              $display("FAIL checkbits inst%0d #%0d: got %h, expected %h", k, rd[k], p[31:16], exp_mem[k][rd[k]]);
            end
            chg_cyc[k][rd[k]] = cyc;
            rd[k]++;
          end
          prev_cb[k] = p[31:16];
        end
      end
    end
  endtask

  task automatic load_prog(input int k);
    for (int i = 0; i < 64; i++) fmem[k][i] = 8'hFF;
    for (int i = 0; i < nprog; i++)
      for (int b = 0; b < 4; b++)
        fmem[k][(int'(base[k]) + 4 * i + b) % 64] = prog[i][8*b +: 8];
  endtask

  // Reference: each non-halt record shows its upper half, stopping at the marker or the word limit.
  task automatic push_expected(input int k);
    int n;
    n = 0;
    exp_final = 16'h0000;
    for (int i = 0; i < nprog; i++) begin
      if (prog[i] == 32'hFFFFFFFF) break;
      exp_mem[k][wr[k]] = prog[i][31:16];
      wr[k]++;
      exp_final = prog[i][31:16];
      n++;
      if (n == maxw[k]) break;
    end
  endtask

  task automatic rand_prog(input int n);
    logic [15:0] hi;
    logic [15:0] last;
    last = 16'h0000;
    for (int i = 0; i < n; i++) begin
      do hi = 16'($urandom_range(1, 16'hFFFE)); while (hi == last);
      prog[i] = {hi, 16'($urandom_range(0, 24))};
      last = hi;
    end
    prog[n] = 32'hFFFFFFFF;
    nprog = n + 1;
  endtask

  task automatic hold_reset(input int k);
    logic [37:0] p;
    @(negedge clk);
    rst[k] = 1'b1;
    #1;
    p = pins(k);
    chk("reset_csb", 64'(csb[k]), 64'd1);
    chk("reset_checkbits", 64'(p[31:16]), 64'h0);
    repeat (2) @(negedge clk);
    chk("reset_flash_clk", 64'(fclk[k]), 64'd0);
    chk("reset_mosi", 64'(mosi[k]), 64'd0);
  endtask

  task automatic release_reset(input int k);
    @(negedge clk);
    rst[k] = 1'b0;
  endtask

  task automatic run_to_halt(input int k);
    int n;
    int t0;
    logic [37:0] p;
    n = 0;
    while (csb[k] && n < 400) begin @(negedge clk); n++; end
    chk("csb_asserted", 64'(n < 400), 64'd1);
    n = 0;
    while (!csb[k] && n < 30000) begin @(negedge clk); n++; end
    chk("halt_reached", 64'(n < 30000), 64'd1);
    t0 = toggles[k];
    repeat (40) @(negedge clk);
    chk("idle_after_halt", 64'(toggles[k]), 64'(t0));
    chk("csb_high_in_halt", 64'(csb[k]), 64'd1);
    chk("records_drained", 64'(rd[k]), 64'(wr[k]));
    p = pins(k);
    chk("final_checkbits", 64'(p[31:16]), 64'(exp_final));
    chk("cmd_addr", 64'(cap[k]), 64'({8'h03, base[k]}));
    chk("io_ownership", 64'(io_bad[k]), 64'd0);
  endtask

  initial begin
    int b;
    int n;
    checks   = 0;
    failures = 0;
    cyc      = 0;
    for (int k = 0; k < 2; k++) begin
      wr[k] = 0; rd[k] = 0; prev_cb[k] = 16'h0; io_bad[k] = 1'b0;
      fcnt[k] = 0; rcnt[k] = 0; toggles[k] = 0; cap[k] = 32'h0;
    end
    fork monitor(); join_none

    hold_reset(0);
    hold_reset(1);

    // boot timing and fixed playback
    prog[0] = 32'hAB400010; prog[1] = 32'hAB410020; prog[2] = 32'hAB510000; prog[3] = 32'hFFFFFFFF;
    nprog = 4;
    load_prog(0);
    b = wr[0];
    push_expected(0);
    @(negedge clk);
    rst[0] = 1'b0;
    repeat (15) @(posedge clk);
    #1 chk("boot_csb_cycle15", 64'(csb[0]), 64'd1);
    @(posedge clk);
    #1 chk("boot_csb_cycle16", 64'(csb[0]), 64'd0);
    run_to_halt(0);
    chk("gap_ab40_ab41", 64'((chg_cyc[0][b+1] - chg_cyc[0][b]) >= 80), 64'd1);

    // halt marker first
    hold_reset(0);
    prog[0] = 32'hFFFFFFFF;
    nprog = 1;
    load_prog(0);
    push_expected(0);
    release_reset(0);
    run_to_halt(0);

    // reset during the second record's fetch
    hold_reset(0);
    rand_prog(3);
    prog[0][15:0] = 16'd2;
    load_prog(0);
    exp_mem[0][wr[0]] = prog[0][31:16];
    wr[0]++;
    release_reset(0);
    n = 0;
    while (rd[0] != wr[0] && n < 2000) begin @(negedge clk); n++; end
    chk("first_record_seen", 64'(n < 2000), 64'd1);
    repeat (10) @(negedge clk);
    chk("in_transfer_csb", 64'(csb[0]), 64'd0);
    hold_reset(0);
    push_expected(0);
    release_reset(0);
    run_to_halt(0);

    // random programs
    for (int s = 0; s < 4; s++) begin
      hold_reset(0);
      rand_prog(int'($urandom_range(1, 6)));
      load_prog(0);
      push_expected(0);
      release_reset(0);
      run_to_halt(0);
    end

    // word limit of two on the second instance
    for (int s = 0; s < 2; s++) begin
      hold_reset(1);
      rand_prog(3);
      load_prog(1);
      push_expected(1);
      release_reset(1);
      run_to_halt(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
